// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like port: request/address phase plus in-order data response.
// The master modport issues requests; the slave modport accepts and answers them.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like slave between the instruction and data masters: zero-latency grant/response,
// data has fixed priority, grant locks while a request waits, owner FIFO routes in-order responses.
module sram_like_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  sram_like_arbiter_if.slave         inst,
  sram_like_arbiter_if.slave         data,
  sram_like_arbiter_if.master        s,
  output logic                       err_orphan
);
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          owner_q [OUTSTANDING];  // 0 = inst, 1 = data
  logic          lock;
  logic          lock_owner;
  logic          err_q;

  logic full, empty, owner, owner_req, grant, push, pop, head;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count == CW'(OUTSTANDING));
  assign empty     = (count == '0);
  assign owner     = lock ? lock_owner : data.req;
  assign owner_req = owner ? data.req : inst.req;
  assign grant     = resetn && !full && owner_req;
  assign push      = grant && s.addr_ok;
  assign pop       = resetn && s.data_ok && !empty;
  assign head      = owner_q[rd_ptr];

  // Request fields are forced to zero whenever nothing is granted.
  assign s.req   = grant;
  assign s.wr    = grant && (owner ? data.wr : inst.wr);
  assign s.size  = grant ? (owner ? data.size  : inst.size)  : 2'b0;
  assign s.addr  = grant ? (owner ? data.addr  : inst.addr)  : 32'b0;
  assign s.wstrb = grant ? (owner ? data.wstrb : inst.wstrb) : 4'b0;
  assign s.wdata = grant ? (owner ? data.wdata : inst.wdata) : 32'b0;

  assign inst.addr_ok = push && !owner;
  assign data.addr_ok = push && owner;
  assign inst.data_ok = pop && !head;
  assign data.data_ok = pop && head;
  assign inst.rdata   = inst.data_ok ? s.rdata : 32'b0;
  assign data.rdata   = data.data_ok ? s.rdata : 32'b0;
  assign err_orphan   = resetn && err_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      lock       <= 1'b0;
      lock_owner <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // A waiting request holds the grant; acceptance or a dropped req releases it.
      lock <= grant && !s.addr_ok;
      if (grant && !s.addr_ok) begin
        lock_owner <= owner;
      end
      if (push) begin
        owner_q[wr_ptr] <= owner;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (s.data_ok && empty) begin
        err_q <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter; expected grants and responses are queued at issue time
// and a negedge monitor compares them whenever the DUT presents an addr_ok or data_ok.
module tb_sram_like_arbiter;
  logic clk = 1'b0;
  logic resetn;
  logic err_orphan;

  always #5 clk = ~clk;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if s_if ();

  sram_like_arbiter #(.OUTSTANDING(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .inst       (inst_if),
    .data       (data_if),
    .s          (s_if),
    .err_orphan (err_orphan)
  );

  typedef struct {
    logic        owner;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
  } rsp_t;

  acc_t exp_acc_q[$];
  rsp_t exp_rsp_q[$];
  acc_t mon_a;
  rsp_t mon_r;
  int   n_checks = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drv_inst(input logic req, input logic [31:0] addr);
    inst_if.req   = req;
    inst_if.wr    = 1'b0;
    inst_if.size  = 2'd2;
    inst_if.addr  = addr;
    inst_if.wstrb = 4'h0;
    inst_if.wdata = 32'h0;
  endtask

  task automatic drv_data(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [3:0] wstrb, input logic [31:0] wdata);
    data_if.req   = req;
    data_if.wr    = wr;
    data_if.size  = 2'd2;
    data_if.addr  = addr;
    data_if.wstrb = wstrb;
    data_if.wdata = wdata;
  endtask

  task automatic drv_slave(input logic aok, input logic dok, input logic [31:0] rd);
    s_if.addr_ok = aok;
    s_if.data_ok = dok;
    s_if.rdata   = rd;
  endtask

  task automatic want_acc(input logic owner, input logic wr, input logic [31:0] addr,
                          input logic [3:0] wstrb, input logic [31:0] wdata);
    acc_t a;
    a.owner = owner; a.wr = wr; a.addr = addr; a.wstrb = wstrb; a.wdata = wdata;
    exp_acc_q.push_back(a);
  endtask

  task automatic want_rsp(input logic owner, input logic [31:0] rdata);
    rsp_t r;
    r.owner = owner; r.rdata = rdata;
    exp_rsp_q.push_back(r);
  endtask

  // Monitor: every address acceptance and every data response is matched against the queues.
  always @(negedge clk) begin
    if ((s_if.req && s_if.addr_ok) || inst_if.addr_ok || data_if.addr_ok) begin
      if (exp_acc_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL acc_unexpected: addr %h accepted, none expected", s_if.addr);
      end else begin
        mon_a = exp_acc_q.pop_front();
        chk("acc_data_addr_ok", {31'b0, data_if.addr_ok}, {31'b0, mon_a.owner});
        chk("acc_inst_addr_ok", {31'b0, inst_if.addr_ok}, {31'b0, !mon_a.owner});
        chk("acc_s_addr", s_if.addr, mon_a.addr);
        chk("acc_s_wr", {31'b0, s_if.wr}, {31'b0, mon_a.wr});
        chk("acc_s_wstrb", {28'b0, s_if.wstrb}, {28'b0, mon_a.wstrb});
        chk("acc_s_wdata", s_if.wdata, mon_a.wdata);
      end
    end
    if (inst_if.data_ok || data_if.data_ok) begin
      if (exp_rsp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL rsp_unexpected: inst_data_ok %b data_data_ok %b, none expected",
                 inst_if.data_ok, data_if.data_ok);
      end else begin
        mon_r = exp_rsp_q.pop_front();
        chk("rsp_data_data_ok", {31'b0, data_if.data_ok}, {31'b0, mon_r.owner});
        chk("rsp_inst_data_ok", {31'b0, inst_if.data_ok}, {31'b0, !mon_r.owner});
        chk("rsp_inst_rdata", inst_if.rdata, mon_r.owner ? 32'h0 : mon_r.rdata);
        chk("rsp_data_rdata", data_if.rdata, mon_r.owner ? mon_r.rdata : 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every input active: all outputs must be held at zero.
    resetn = 1'b0;
    drv_inst(1'b1, 32'h1c000000);
    drv_data(1'b1, 1'b1, 32'h1c001000, 4'hF, 32'h12345678);
    drv_slave(1'b1, 1'b1, 32'hFFFFFFFF);
    step(); step(); settle();
    chk("rst_s_req", {31'b0, s_if.req}, 32'h0);
    chk("rst_s_wr", {31'b0, s_if.wr}, 32'h0);
    chk("rst_s_addr", s_if.addr, 32'h0);
    chk("rst_s_wdata", s_if.wdata, 32'h0);
    chk("rst_s_wstrb", {28'b0, s_if.wstrb}, 32'h0);
    chk("rst_s_size", {30'b0, s_if.size}, 32'h0);
    chk("rst_inst_addr_ok", {31'b0, inst_if.addr_ok}, 32'h0);
    chk("rst_data_addr_ok", {31'b0, data_if.addr_ok}, 32'h0);
    chk("rst_inst_data_ok", {31'b0, inst_if.data_ok}, 32'h0);
    chk("rst_data_data_ok", {31'b0, data_if.data_ok}, 32'h0);
    chk("rst_inst_rdata", inst_if.rdata, 32'h0);
    chk("rst_data_rdata", data_if.rdata, 32'h0);
    chk("rst_err_orphan", {31'b0, err_orphan}, 32'h0);

    step();
    resetn = 1'b1;
    drv_inst(1'b0, 32'h0);
    drv_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drv_slave(1'b0, 1'b0, 32'h0);
    settle();
    chk("idle_s_req", {31'b0, s_if.req}, 32'h0);
    chk("idle_err_orphan", {31'b0, err_orphan}, 32'h0);

    // Single instruction read, response two cycles after acceptance.
    step();
    drv_inst(1'b1, 32'h1c000000);
    drv_slave(1'b1, 1'b0, 32'h0);
    want_acc(1'b0, 1'b0, 32'h1c000000, 4'h0, 32'h0);
    want_rsp(1'b0, 32'h02800000);
    settle();
    chk("t1_inst_addr_ok", {31'b0, inst_if.addr_ok}, 32'h1);
    chk("t1_s_size", {30'b0, s_if.size}, 32'h2);
    step();
    drv_inst(1'b0, 32'h0);
    drv_slave(1'b0, 1'b0, 32'h0);
    step();
    drv_slave(1'b0, 1'b1, 32'h02800000);
    settle();
    chk("t1_data_data_ok", {31'b0, data_if.data_ok}, 32'h0);
    step();
    drv_slave(1'b0, 1'b0, 32'h0);

    // Conflict: data store wins, inst follows, responses return in that order.
    step();
    drv_inst(1'b1, 32'h1c000004);
    drv_data(1'b1, 1'b1, 32'h1c001000, 4'hF, 32'h12345678);
    drv_slave(1'b1, 1'b0, 32'h0);
    want_acc(1'b1, 1'b1, 32'h1c001000, 4'hF, 32'h12345678);
    want_acc(1'b0, 1'b0, 32'h1c000004, 4'h0, 32'h0);
    want_rsp(1'b1, 32'h11111111);
    want_rsp(1'b0, 32'h22222222);
    settle();
    chk("t2_first_addr", s_if.addr, 32'h1c001000);
    chk("t2_first_wr", {31'b0, s_if.wr}, 32'h1);
    step();
    drv_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    settle();
    chk("t2_second_addr", s_if.addr, 32'h1c000004);
    step();
    drv_inst(1'b0, 32'h0);
    drv_slave(1'b0, 1'b1, 32'h11111111);
    step();
    drv_slave(1'b0, 1'b1, 32'h22222222);
    step();
    drv_slave(1'b0, 1'b0, 32'h0);

    // Lock: inst waits three cycles; a data request raised meanwhile must not preempt it.
    step();
    drv_inst(1'b1, 32'h1c000008);
    settle();
    chk("t3_c0_addr", s_if.addr, 32'h1c000008);
    for (int c = 1; c < 3; c++) begin
      step();
      drv_data(1'b1, 1'b0, 32'h1c002000, 4'h0, 32'h0);
      settle();
      chk("t3_locked_addr", s_if.addr, 32'h1c000008);
      chk("t3_locked_s_req", {31'b0, s_if.req}, 32'h1);
      chk("t3_locked_data_addr_ok", {31'b0, data_if.addr_ok}, 32'h0);
    end
    step();
    drv_slave(1'b1, 1'b0, 32'h0);
    want_acc(1'b0, 1'b0, 32'h1c000008, 4'h0, 32'h0);
    want_rsp(1'b0, 32'h33333333);
    step();
    drv_inst(1'b0, 32'h0);
    want_acc(1'b1, 1'b0, 32'h1c002000, 4'h0, 32'h0);
    want_rsp(1'b1, 32'h44444444);
    settle();
    chk("t3_data_after_lock", s_if.addr, 32'h1c002000);
    step();
    drv_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drv_slave(1'b0, 1'b1, 32'h33333333);
    step();
    drv_slave(1'b0, 1'b1, 32'h44444444);
    step();
    drv_slave(1'b0, 1'b0, 32'h0);

    // Backpressure: full FIFO blocks the third request even with a same-cycle pop.
    step();
    drv_inst(1'b1, 32'h1c000010);
    drv_slave(1'b1, 1'b0, 32'h0);
    want_acc(1'b0, 1'b0, 32'h1c000010, 4'h0, 32'h0);
    want_rsp(1'b0, 32'hA1A1A1A1);
    step();
    drv_inst(1'b1, 32'h1c000014);
    want_acc(1'b0, 1'b0, 32'h1c000014, 4'h0, 32'h0);
    want_rsp(1'b0, 32'hA2A2A2A2);
    step();
    drv_inst(1'b1, 32'h1c000018);
    drv_slave(1'b1, 1'b1, 32'hA1A1A1A1);
    settle();
    chk("t4_full_s_req", {31'b0, s_if.req}, 32'h0);
    chk("t4_full_inst_addr_ok", {31'b0, inst_if.addr_ok}, 32'h0);
    chk("t4_full_s_addr", s_if.addr, 32'h0);
    step();
    drv_slave(1'b1, 1'b0, 32'h0);
    want_acc(1'b0, 1'b0, 32'h1c000018, 4'h0, 32'h0);
    want_rsp(1'b0, 32'hA3A3A3A3);
    settle();
    chk("t4_retry_addr_ok", {31'b0, inst_if.addr_ok}, 32'h1);
    step();
    drv_inst(1'b0, 32'h0);
    drv_slave(1'b0, 1'b1, 32'hA2A2A2A2);
    step();
    drv_slave(1'b0, 1'b1, 32'hA3A3A3A3);
    step();
    drv_slave(1'b0, 1'b0, 32'h0);

    // Interleave inst/data/inst with a simultaneous push and pop; FIFO wraps.
    step();
    drv_inst(1'b1, 32'h1c000100);
    drv_slave(1'b1, 1'b0, 32'h0);
    want_acc(1'b0, 1'b0, 32'h1c000100, 4'h0, 32'h0);
    want_rsp(1'b0, 32'hAAAA0001);
    step();
    drv_inst(1'b0, 32'h0);
    drv_data(1'b1, 1'b0, 32'h1c000200, 4'h0, 32'h0);
    want_acc(1'b1, 1'b0, 32'h1c000200, 4'h0, 32'h0);
    want_rsp(1'b1, 32'hBBBB0002);
    step();
    drv_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drv_slave(1'b0, 1'b1, 32'hAAAA0001);
    step();
    drv_inst(1'b1, 32'h1c000300);
    drv_slave(1'b1, 1'b1, 32'hBBBB0002);
    want_acc(1'b0, 1'b0, 32'h1c000300, 4'h0, 32'h0);
    want_rsp(1'b0, 32'hCCCC0003);
    step();
    drv_inst(1'b0, 32'h0);
    drv_slave(1'b0, 1'b1, 32'hCCCC0003);
    step();
    drv_slave(1'b0, 1'b0, 32'h0);

    // Orphan on an empty FIFO: flagged, no master response, count stays at zero.
    step();
    drv_slave(1'b0, 1'b1, 32'hBAD0BAD0);
    settle();
    chk("orphan_inst_data_ok", {31'b0, inst_if.data_ok}, 32'h0);
    chk("orphan_data_data_ok", {31'b0, data_if.data_ok}, 32'h0);
    step();
    drv_slave(1'b0, 1'b0, 32'h0);
    settle();
    chk("orphan_err", {31'b0, err_orphan}, 32'h1);
    step();
    drv_inst(1'b1, 32'h1c000400);
    drv_slave(1'b1, 1'b0, 32'h0);
    want_acc(1'b0, 1'b0, 32'h1c000400, 4'h0, 32'h0);
    settle();
    chk("nounder_ok1", {31'b0, inst_if.addr_ok}, 32'h1);
    step();
    drv_inst(1'b1, 32'h1c000404);
    want_acc(1'b0, 1'b0, 32'h1c000404, 4'h0, 32'h0);
    settle();
    chk("nounder_ok2", {31'b0, inst_if.addr_ok}, 32'h1);
    step();
    drv_inst(1'b1, 32'h1c000408);
    settle();
    chk("nounder_full_s_req", {31'b0, s_if.req}, 32'h0);
    chk("orphan_err_sticky", {31'b0, err_orphan}, 32'h1);

    // Reset with two outstanding flushes the FIFO; a late response is an orphan.
    step();
    resetn = 1'b0;
    drv_inst(1'b0, 32'h0);
    drv_slave(1'b0, 1'b0, 32'h0);
    step();
    resetn = 1'b1;
    settle();
    chk("post_rst_err", {31'b0, err_orphan}, 32'h0);
    step();
    drv_slave(1'b0, 1'b1, 32'h5555AAAA);
    settle();
    chk("post_rst_inst_data_ok", {31'b0, inst_if.data_ok}, 32'h0);
    chk("post_rst_data_data_ok", {31'b0, data_if.data_ok}, 32'h0);
    step();
    drv_slave(1'b0, 1'b0, 32'h0);
    settle();
    chk("post_rst_orphan_err", {31'b0, err_orphan}, 32'h1);

    step();
    settle();
    chk("acc_queue_drained", exp_acc_q.size(), 32'h0);
    chk("rsp_queue_drained", exp_rsp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
